// File: rtl/regs_mp.sv
// Parametrised multi-port general-register file: registered read addresses,
// per-port writes with highest-port priority, optional write bypass, sticky collision flag.
module regs_mp #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NR     = 4,
  parameter int unsigned NW     = 4,
  parameter bit          BYPASS = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NR*$clog2(DEPTH)-1:0] raddr,
  output logic [NR*WIDTH-1:0] rdata,
  input  logic [NW-1:0]       wen,
  input  logic [NW*$clog2(DEPTH)-1:0] waddr,
  input  logic [NW*WIDTH-1:0] wdata,
  output logic                collide
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q   [DEPTH];
  logic [WIDTH-1:0] mem_d   [DEPTH];
  logic [AW-1:0]    raddr_q [NR];
  logic             collide_q;
  logic             collide_d;
  logic [NW-1:0]    wvalid_c;

  // Addresses at or beyond DEPTH exist only when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(DEPTH);
  endfunction

  // A write port participates only when enabled and aimed at a real register.
  always_comb begin
    wvalid_c = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      wvalid_c[j] = wen[j] & in_range(waddr[j*AW +: AW]);
    end
  end

  // Ascending port order lets the highest-index port overwrite lower ones.
  always_comb begin
    mem_d     = mem_q;
    collide_d = collide_q;
    for (int unsigned j = 0; j < NW; j++) begin
      if (wvalid_c[j]) begin
        mem_d[waddr[j*AW +: AW]] = wdata[j*WIDTH +: WIDTH];
      end
      for (int unsigned k = j + 1; k < NW; k++) begin
        if (wvalid_c[j] && wvalid_c[k] &&
            (waddr[j*AW +: AW] == waddr[k*AW +: AW])) begin
          collide_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned d = 0; d < DEPTH; d++) begin
        mem_q[d] <= '0;
      end
      for (int unsigned i = 0; i < NR; i++) begin
        raddr_q[i] <= '0;
      end
      collide_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      for (int unsigned i = 0; i < NR; i++) begin
        raddr_q[i] <= raddr[i*AW +: AW];
      end
      collide_q <= collide_d;
    end
  end

  // Read mux; bypass is held off during reset so rdata stays zero.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (in_range(raddr_q[i])) begin
        rdata[i*WIDTH +: WIDTH] = mem_q[raddr_q[i]];
      end
      if (BYPASS && rst_n) begin
        for (int unsigned j = 0; j < NW; j++) begin
          if (wvalid_c[j] && (waddr[j*AW +: AW] == raddr_q[i])) begin
            rdata[i*WIDTH +: WIDTH] = wdata[j*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign collide = collide_q;

endmodule
